lvds_tx_framer: RTL and testbench

Parametrised parallel-side transmit framer feeding a bank of N-lane, RATIO:1 output serializers and one forwarded-clock serializer. Runs in the divided word-clock domain. Sequences link bring-up (serializer reset hold, training pattern, data), buffers the upstream stream through a valid/ready handshake and inserts idle words on underflow. Sits between the video/data source and the OSERDES/OBUFDS layer.

---
 rtl/lvds_tx_framer_if.sv | 17 +
 rtl/lvds_tx_framer.sv | 187 ++++++++++++++++++
 tb/tb_lvds_tx_framer.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lvds_tx_framer_if.sv
// Upstream word-stream handshake between the video/data source and the
// LVDS transmit framer.
//   s_data  : LANES*RATIO bits, lane i = s_data[i*RATIO +: RATIO]
//   s_valid : source has a word on s_data
//   s_ready : framer accepts the word this cycle
// master = source side, slave = framer side.
interface lvds_tx_framer_if #(
    parameter int LANES = 4,
    parameter int RATIO = 7
);
    logic [LANES*RATIO-1:0] s_data;
    logic                   s_valid;
    logic                   s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/lvds_tx_framer.sv
// Parallel-side transmit framer for a bank of LANES x RATIO:1 serializers
// plus a forwarded-clock serializer. Runs in the divided word-clock domain.
// Brings the link up (serializer reset hold -> training pattern -> data),
// buffers upstream words in a 2-entry FIFO and sends idle words on underflow.
//   clk, rst       : word clock, synchronous active-high reset
//   enable         : link enable, low forces IDLE
//   train_req      : one-cycle retrain request, honoured in DATA only
//   s              : upstream valid/ready word stream (slave side)
//   ser_data       : per-lane serializer words, bit 0 -> D1
//   ser_clk_word   : forwarded-clock serializer word
//   ser_rst        : serializer reset
//   link_up        : high in DATA
//   state          : 0 IDLE, 1 HOLD, 2 TRAIN, 3 DATA
//   underflow_cnt  : saturating count of idle words inserted in DATA

// Per-lane data word ordering: pass-through or bit reversal within the lane.
module lvds_tx_framer_lane #(
    parameter int RATIO     = 7,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic [RATIO-1:0] word_in,
    output logic [RATIO-1:0] word_out
);
    generate
        if (MSB_FIRST) begin : g_rev
            for (genvar k = 0; k < RATIO; k++) begin : g_bit
                assign word_out[k] = word_in[RATIO-1-k];
            end
        end else begin : g_fwd
            assign word_out = word_in;
        end
    endgenerate
endmodule

module lvds_tx_framer #(
    parameter int               LANES         = 4,
    parameter int               RATIO         = 7,
    parameter logic [RATIO-1:0] CLOCK_PATTERN = 7'b1100011,
    parameter logic [RATIO-1:0] TRAIN_PATTERN = 7'b0001111,
    parameter logic [RATIO-1:0] IDLE_WORD     = 7'b0000000,
    parameter int               RST_CYCLES    = 8,
    parameter int               TRAIN_CYCLES  = 256,
    parameter bit               MSB_FIRST     = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   train_req,
    lvds_tx_framer_if.slave        s,
    output logic [LANES*RATIO-1:0] ser_data,
    output logic [RATIO-1:0]       ser_clk_word,
    output logic                   ser_rst,
    output logic                   link_up,
    output logic [1:0]             state,
    output logic [15:0]            underflow_cnt
);
    typedef logic [LANES-1:0][RATIO-1:0] lanes_t;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_TRAIN = 2'd2,
        ST_DATA  = 2'd3
    } state_t;

    localparam int     CNT_MAX   = (RST_CYCLES > TRAIN_CYCLES) ? RST_CYCLES : TRAIN_CYCLES;
    localparam int     CW        = $clog2(CNT_MAX + 1);
    localparam lanes_t IDLE_ALL  = {LANES{IDLE_WORD}};
    localparam lanes_t TRAIN_ALL = {LANES{TRAIN_PATTERN}};

    state_t        st;
    logic [CW-1:0] cnt;
    lanes_t        ser_q;

    // 2-entry FIFO; pointers are single bits since depth is fixed at 2
    lanes_t        fifo_mem [2];
    logic          wr_ptr, rd_ptr;
    logic [1:0]    fifo_cnt;
    lanes_t        head, head_out;
    logic          push, pop;

    assign s.s_ready = (st == ST_DATA) && (fifo_cnt < 2'd2);
    assign push      = s.s_valid && s.s_ready;
    assign pop       = (fifo_cnt != 2'd0);
    assign head      = fifo_mem[rd_ptr];

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            lvds_tx_framer_lane #(
                .RATIO     (RATIO),
                .MSB_FIRST (MSB_FIRST)
            ) u_lane (
                .word_in  (head[i]),
                .word_out (head_out[i])
            );
        end
    endgenerate

    // Storage only; occupancy and pointers live in the control block, so a
    // write that coincides with a flush is simply never read.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= s.s_data;
    end

    // Outputs are registered alongside the state so they switch on the same
    // edge as the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            st            <= ST_IDLE;
            cnt           <= '0;
            ser_q         <= '0;
            ser_clk_word  <= '0;
            ser_rst       <= 1'b1;
            link_up       <= 1'b0;
            underflow_cnt <= '0;
            fifo_cnt      <= '0;
            wr_ptr        <= 1'b0;
            rd_ptr        <= 1'b0;
        end else if (!enable) begin
            // enable low beats train_req and counter expiry
            st           <= ST_IDLE;
            ser_q        <= IDLE_ALL;
            ser_clk_word <= '0;
            ser_rst      <= 1'b1;
            link_up      <= 1'b0;
            fifo_cnt     <= '0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
        end else begin
            case (st)
                ST_IDLE: begin
                    st    <= ST_HOLD;
                    cnt   <= CW'(RST_CYCLES);
                    ser_q <= IDLE_ALL;
                end
                ST_HOLD: begin
                    if (cnt == CW'(1)) begin
                        st           <= ST_TRAIN;
                        cnt          <= CW'(TRAIN_CYCLES);
                        ser_rst      <= 1'b0;
                        ser_q        <= TRAIN_ALL;
                        ser_clk_word <= CLOCK_PATTERN;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_TRAIN: begin
                    if (cnt == CW'(1)) begin
                        // FIFO is empty here, so the first DATA word is idle
                        st      <= ST_DATA;
                        link_up <= 1'b1;
                        ser_q   <= IDLE_ALL;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_DATA: begin
                    if (train_req) begin
                        st       <= ST_TRAIN;
                        cnt      <= CW'(TRAIN_CYCLES);
                        link_up  <= 1'b0;
                        ser_q    <= TRAIN_ALL;
                        fifo_cnt <= '0;
                        wr_ptr   <= 1'b0;
                        rd_ptr   <= 1'b0;
                    end else begin
                        if (push)
                            wr_ptr <= ~wr_ptr;
                        if (pop) begin
                            ser_q  <= head_out;
                            rd_ptr <= ~rd_ptr;
                        end else begin
                            ser_q <= IDLE_ALL;
                            if (underflow_cnt != 16'hFFFF)
                                underflow_cnt <= underflow_cnt + 16'd1;
                        end
                        fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
                    end
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

    assign ser_data = ser_q;
    assign state    = st;
endmodule

// File: tb/tb_lvds_tx_framer.sv
// Self-checking bench for lvds_tx_framer. Two instances share identical
// stimulus: one LSB-first, one MSB-first. A cycle-level reference model
// (phase + age counter + word queue) predicts every output after each edge.
module tb_lvds_tx_framer;
    localparam int               LANES   = 4;
    localparam int               RATIO   = 7;
    localparam int               W       = LANES * RATIO;
    localparam logic [RATIO-1:0] CLK_PAT = 7'b1100011;
    localparam logic [RATIO-1:0] TRN     = 7'b0001111;
    localparam logic [RATIO-1:0] IDL     = 7'b0000000;
    localparam int               RST_CYC = 8;
    localparam int               TRN_CYC = 256;

    logic clk = 1'b0;
    logic rst, enable, train_req;
    logic [W-1:0]     ser_data0, ser_data1;
    logic [RATIO-1:0] ser_clk_word0, ser_clk_word1;
    logic             ser_rst0, ser_rst1, link_up0, link_up1;
    logic [1:0]       state0, state1;
    logic [15:0]      uf0, uf1;

    lvds_tx_framer_if #(.LANES(LANES), .RATIO(RATIO)) if0 ();
    lvds_tx_framer_if #(.LANES(LANES), .RATIO(RATIO)) if1 ();

    lvds_tx_framer #(.LANES(LANES), .RATIO(RATIO), .MSB_FIRST(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .enable(enable), .train_req(train_req), .s(if0.slave),
        .ser_data(ser_data0), .ser_clk_word(ser_clk_word0), .ser_rst(ser_rst0),
        .link_up(link_up0), .state(state0), .underflow_cnt(uf0)
    );
    lvds_tx_framer #(.LANES(LANES), .RATIO(RATIO), .MSB_FIRST(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .enable(enable), .train_req(train_req), .s(if1.slave),
        .ser_data(ser_data1), .ser_clk_word(ser_clk_word1), .ser_rst(ser_rst1),
        .link_up(link_up1), .state(state1), .underflow_cnt(uf1)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // reference model
    int           m_state = 0;
    int           m_age   = 0;
    int           m_uf    = 0;
    logic [W-1:0] m_q[$];
    logic [W-1:0] m_out0  = '0;
    logic [W-1:0] m_out1  = '0;

    function automatic logic [W-1:0] rep(input logic [RATIO-1:0] x);
        return {LANES{x}};
    endfunction

    function automatic logic [W-1:0] rev(input logic [W-1:0] x);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++)
            for (int k = 0; k < RATIO; k++)
                r[i*RATIO + k] = x[i*RATIO + RATIO - 1 - k];
        return r;
    endfunction

    task automatic set_out(input logic [W-1:0] w0, input logic [W-1:0] w1);
        m_out0 = w0;
        m_out1 = w1;
    endtask

    task automatic model_edge();
        logic [W-1:0] w;
        bit push;
        push = (if0.s_valid === 1'b1) && (m_state == 3) && (m_q.size() < 2);
        if (rst) begin
            m_state = 0; m_q.delete(); set_out('0, '0); m_uf = 0;
        end else if (!enable) begin
            m_state = 0; m_q.delete(); set_out(rep(IDL), rep(IDL));
        end else begin
            case (m_state)
                0: begin m_state = 1; m_age = 0; set_out(rep(IDL), rep(IDL)); end
                1: begin
                    m_age++;
                    if (m_age == RST_CYC) begin m_state = 2; m_age = 0; set_out(rep(TRN), rep(TRN)); end
                end
                2: begin
                    m_age++;
                    if (m_age == TRN_CYC) begin m_state = 3; set_out(rep(IDL), rep(IDL)); end
                end
                default: begin
                    if (train_req) begin
                        m_state = 2; m_age = 0; m_q.delete(); set_out(rep(TRN), rep(TRN));
                    end else begin
                        if (m_q.size() > 0) begin
                            w = m_q.pop_front();
                            set_out(w, rev(w));
                        end else begin
                            set_out(rep(IDL), rep(IDL));
                            if (m_uf < 65535) m_uf++;
                        end
                        if (push) m_q.push_back(if0.s_data);
                    end
                end
            endcase
        end
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [RATIO-1:0] cw;
        cw = (m_state >= 2) ? CLK_PAT : '0;
        chk("state0",   W'(state0),   W'(m_state));
        chk("state1",   W'(state1),   W'(m_state));
        chk("ser_rst",  W'(ser_rst0), W'(m_state <= 1));
        chk("ser_rst1", W'(ser_rst1), W'(m_state <= 1));
        chk("link_up",  W'(link_up0), W'(m_state == 3));
        chk("link_up1", W'(link_up1), W'(m_state == 3));
        chk("clk_word", W'(ser_clk_word0), W'(cw));
        chk("clk_word1", W'(ser_clk_word1), W'(cw));
        chk("s_ready",  W'(if0.s_ready), W'((m_state == 3) && (m_q.size() < 2)));
        chk("s_ready1", W'(if1.s_ready), W'((m_state == 3) && (m_q.size() < 2)));
        chk("ser_data_lsb", ser_data0, m_out0);
        chk("ser_data_msb", ser_data1, m_out1);
        chk("underflow", W'(uf0), W'(m_uf));
        chk("underflow1", W'(uf1), W'(m_uf));
    endtask

    task automatic drive(input logic en, input logic tr, input logic v, input logic [W-1:0] d);
        enable = en; train_req = tr;
        if0.s_valid = v; if0.s_data = d;
        if1.s_valid = v; if1.s_data = d;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic wait_data(input string tag);
        int n;
        n = 0;
        while (m_state != 3 && n < 400) begin step(); n++; end
        chk(tag, W'(state0), W'(2'd3));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0);

        // reset values
        step(); step();
        chk("rst_ser_rst", W'(ser_rst0), W'(1'b1));
        chk("rst_data", ser_data0, '0);

        // bring-up: 1 edge to HOLD, 8 HOLD, 256 TRAIN
        rst = 1'b0;
        drive(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 1 + RST_CYC + TRN_CYC; i++) step();
        chk("up_state", W'(state0), W'(2'd3));
        chk("up_link", W'(link_up0), W'(1'b1));
        chk("up_ready", W'(if0.s_ready), W'(1'b1));

        // back-to-back incrementing stream
        for (int i = 1; i <= 20; i++) begin
            drive(1'b1, 1'b0, 1'b1, W'(i));
            step();
            if (i == 2) begin
                chk("lat_first", ser_data0, W'(1));
                chk("msb_first", ser_data1, W'(28'h0000040));
            end
        end
        drive(1'b1, 1'b0, 1'b0, '0);
        step(); step();

        // randomized traffic with occasional retrain requests
        for (int i = 0; i < 400; i++) begin
            drive(1'b1, ($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)),
                  W'({$urandom, $urandom}));
            step();
        end
        drive(1'b1, 1'b0, 1'b0, '0);
        wait_data("rand_resync");

        // underflow: 3 idle words, then saturation
        step();
        base = int'(uf0);
        step(); step(); step();
        chk("uf_plus3", W'(uf0), W'(base + 3));
        for (int i = 0; i < 70000 && m_uf < 65534; i++) step();
        chk("uf_fffe", W'(uf0), W'(16'hFFFE));
        step(); step(); step();
        chk("uf_sat", W'(uf0), W'(16'hFFFF));

        // retrain mid-stream: in-flight words dropped
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b1, W'({$urandom, $urandom}));
            step();
        end
        drive(1'b1, 1'b1, 1'b1, W'({$urandom, $urandom}));
        step();
        chk("retrain_ready", W'(if0.s_ready), W'(1'b0));
        chk("retrain_state", W'(state0), W'(2'd2));
        drive(1'b1, 1'b0, 1'b1, W'({$urandom, $urandom}));
        wait_data("retrain_done");
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 1'b1, W'({$urandom, $urandom}));
            step();
        end

        // enable drop during TRAIN
        drive(1'b1, 1'b1, 1'b0, '0);
        step();
        drive(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 50; i++) step();
        drive(1'b0, 1'b0, 1'b0, '0);
        step();
        chk("dis_state", W'(state0), W'(2'd0));
        chk("dis_ser_rst", W'(ser_rst0), W'(1'b1));

        // rst mid-DATA, enable held high
        drive(1'b1, 1'b0, 1'b0, '0);
        wait_data("reup");
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 1'b1, W'({$urandom, $urandom}));
            step();
        end
        rst = 1'b1;
        step();
        chk("mid_rst_state", W'(state0), W'(2'd0));
        chk("mid_rst_data", ser_data0, '0);
        chk("mid_rst_uf", W'(uf0), '0);
        chk("mid_rst_ready", W'(if0.s_ready), W'(1'b0));
        rst = 1'b0;
        step();
        chk("post_rst_hold", W'(state0), W'(2'd1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
